serial_to_spi: RTL and testbench

//   Bridges a UART host to an SPI slave. Each 8N1 byte received on tx is shifted out on SPI
//   (mode 0, MSB first). The byte captured from miso during that transfer is returned to the

---
 rtl/serial_to_spi.sv | 202 ++++++++++++++++++++
 tb/tb_serial_to_spi.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_spi.sv
// UART-to-SPI bridge: each received 8N1 byte is shifted out on SPI mode 0,
// and the byte captured from miso is returned to the host as one 8N1 byte.
module serial_to_spi #(
    parameter int CLKS_PER_BIT = 32,
    parameter int SCK_HALF     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tx,
    output logic rx,
    input  logic rts,
    output logic cts,
    output logic sck,
    output logic mosi,
    input  logic miso
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] C_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] C_SCK  = CW'(SCK_HALF - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RX_START = 3'd1;
    localparam logic [2:0] S_RX_DATA  = 3'd2;
    localparam logic [2:0] S_RX_STOP  = 3'd3;
    localparam logic [2:0] S_SPI      = 3'd4;
    localparam logic [2:0] S_TX_WAIT  = 3'd5;
    localparam logic [2:0] S_TX       = 3'd6;

    logic          r_tx_s1;
    logic          r_tx_s2;
    logic          r_rts_s1;
    logic          r_rts_s2;
    logic          r_miso_s1;
    logic          r_miso_s2;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_rx;
    logic          r_cts;
    logic          r_sck;
    logic          r_mosi;

    logic w_tx;
    logic w_rts;
    logic w_miso;

    assign w_tx   = r_tx_s2;
    assign w_rts  = r_rts_s2;
    assign w_miso = r_miso_s2;

    assign rx   = r_rx;
    assign cts  = r_cts;
    assign sck  = r_sck;
    assign mosi = r_mosi;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_s1   <= 1'b1;
            r_tx_s2   <= 1'b1;
            r_rts_s1  <= 1'b0;
            r_rts_s2  <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_rx      <= 1'b1;
            r_cts     <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            r_tx_s1   <= tx;
            r_tx_s2   <= r_tx_s1;
            r_rts_s1  <= rts;
            r_rts_s2  <= r_rts_s1;
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;

            unique case (r_state)
                S_IDLE: begin
                    r_cts <= 1'b1;
                    r_rx  <= 1'b1;
                    if (!w_tx) begin
                        r_state <= S_RX_START;
                        r_cts   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end

                S_RX_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        if (w_tx) begin
                            r_state <= S_IDLE;
                            r_cts   <= 1'b1;
                        end else begin
                            r_state <= S_RX_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_RX_DATA: begin
                    if (r_cnt == C_BIT) begin
                        r_cnt   <= '0;
                        r_shift <= {w_tx, r_shift[7:1]};
                        if (r_bit == 4'd7) begin
                            r_bit   <= '0;
                            r_state <= S_RX_STOP;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_RX_STOP: begin
                    if (r_cnt == C_BIT) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        if (w_tx) begin
                            r_state <= S_SPI;
                            r_mosi  <= r_shift[7];
                            r_sck   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_cts   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                // r_shift shifts left on each rise: out goes the sent bit,
                // in comes miso, so it ends holding the reply byte.
                S_SPI: begin
                    if (r_cnt == C_SCK) begin
                        r_cnt <= '0;
                        if (!r_sck) begin
                            r_sck   <= 1'b1;
                            r_shift <= {r_shift[6:0], w_miso};
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == 4'd7) begin
                                r_bit   <= '0;
                                r_mosi  <= 1'b0;
                                r_state <= S_TX_WAIT;
                            end else begin
                                r_bit  <= r_bit + 4'd1;
                                r_mosi <= r_shift[7];
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_TX_WAIT: begin
                    r_rx <= 1'b1;
                    if (w_rts) begin
                        r_state <= S_TX;
                        r_rx    <= 1'b0;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end

                // r_bit: 0 start, 1..8 data, 9 stop
                S_TX: begin
                    if (r_cnt == C_BIT) begin
                        r_cnt <= '0;
                        if (r_bit == 4'd9) begin
                            r_bit   <= '0;
                            r_state <= S_IDLE;
                            r_cts   <= 1'b1;
                            r_rx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                            r_rx  <= (r_bit == 4'd8) ? 1'b1
                                                     : r_shift[r_bit[2:0]];
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_to_spi.sv
// Directed self-checking bench for serial_to_spi with a behavioural
// UART host and an SPI slave that presents its next bit after each sck rise.
module tb_serial_to_spi;

    localparam int  CPB  = 32;
    localparam int  HALF = 2;
    localparam time TCLK = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx    = 1'b1;
    logic rts   = 1'b1;
    logic miso;
    wire  rx;
    wire  cts;
    wire  sck;
    wire  mosi;

    int errors = 0;
    int checks = 0;

    int         total_rises = 0;
    int         base        = 0;
    int         bad_int     = 0;
    int         w_idx;
    time        last_rise   = 0;
    logic [7:0] mosi_cap    = 8'h00;
    logic [7:0] slave_data  = 8'h00;

    always #(TCLK / 2) clk = ~clk;

    serial_to_spi #(
        .CLKS_PER_BIT(CPB),
        .SCK_HALF    (HALF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .tx   (tx),
        .rx   (rx),
        .rts  (rts),
        .cts  (cts),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso)
    );

    always_comb w_idx = total_rises - base;

    // The master samples a 2-flop synchronised miso, so the slave must
    // present the next bit well ahead of the next rise.
    always_comb begin
        miso = 1'b0;
        if (w_idx >= 0 && w_idx < 8) miso = slave_data[3'(7 - w_idx)];
    end

    always @(posedge sck) begin
        if (w_idx >= 0 && w_idx < 8) mosi_cap[3'(7 - w_idx)] <= mosi;
        if (w_idx >= 1 && w_idx < 8 && ($time - last_rise) != 2 * HALF * TCLK)
            bad_int <= bad_int + 1;
        last_rise   <= $time;
        total_rises <= total_rises + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] b);
        tx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            tx = b[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_data(b);
        tx = 1'b1;
        tick(CPB);
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic ok);
        int n;
        n  = 0;
        ok = 1'b1;
        d  = 8'h00;
        @(negedge clk);
        while (rx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) @(negedge clk);
        if (rx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            d[i] = rx;
        end
        repeat (CPB) @(negedge clk);
        if (rx !== 1'b1) ok = 1'b0;
    endtask

    task automatic wait_cts(output logic ok);
        int n;
        n = 0;
        while (cts !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        ok = (cts === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if (rx !== 1'b1) begin
            errors++; $display("FAIL reset_rx: got %b want 1", rx);
        end
        checks++;
        if (sck !== 1'b0) begin
            errors++; $display("FAIL reset_sck: got %b want 0", sck);
        end
        checks++;
        if (mosi !== 1'b0) begin
            errors++; $display("FAIL reset_mosi: got %b want 0", mosi);
        end
        checks++;
        if (cts !== 1'b0) begin
            errors++; $display("FAIL reset_cts: got %b want 0", cts);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (cts !== 1'b0) begin
            errors++; $display("FAIL release_cts_early: got %b want 0", cts);
        end
        tick(1);
        checks++;
        if (cts !== 1'b1) begin
            errors++; $display("FAIL release_cts: got %b want 1", cts);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       ok;
        int         b0;
        base       = total_rises;
        b0         = bad_int;
        slave_data = 8'h3C;
        send_byte(8'hA5);
        recv_byte(d, ok);
        checks++;
        if (mosi_cap !== 8'hA5) begin
            errors++; $display("FAIL basic_mosi: got %h want a5", mosi_cap);
        end
        checks++;
        if (total_rises - base != 8) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 8", total_rises - base);
        end
        checks++;
        if (bad_int != b0) begin
            errors++;
            $display("FAIL basic_sck_rate: got %0d bad periods want 0",
                     bad_int - b0);
        end
        checks++;
        if (!ok || d !== 8'h3C) begin
            errors++;
            $display("FAIL basic_reply: got %h ok=%b want 3c ok=1", d, ok);
        end
    endtask

    task automatic test_rts();
        logic [7:0] d;
        logic       ok;
        int         viol;
        ok = 1'b0;
        wait_cts(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rts_cts_ready: got %b want 1", cts);
        end
        rts        = 1'b0;
        base       = total_rises;
        slave_data = 8'h42;
        send_byte(8'h81);
        viol = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (rx !== 1'b1 || cts !== 1'b0) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL rts_hold: got %0d bad cycles want 0", viol);
        end
        checks++;
        if (mosi_cap !== 8'h81 || total_rises - base != 8) begin
            errors++;
            $display("FAIL rts_spi: got %h/%0d want 81/8", mosi_cap,
                     total_rises - base);
        end
        rts = 1'b1;
        tick(3);
        checks++;
        if (rx !== 1'b0) begin
            errors++; $display("FAIL rts_start: got %b want 0", rx);
        end
        rts = 1'b0;
        recv_byte(d, ok);
        checks++;
        if (!ok || d !== 8'h42) begin
            errors++;
            $display("FAIL rts_reply: got %h ok=%b want 42 ok=1", d, ok);
        end
        rts = 1'b1;
    endtask

    task automatic test_glitch();
        logic ok;
        logic saw_low;
        int   r0;
        int   viol;
        ok = 1'b0;
        wait_cts(ok);
        r0      = total_rises;
        saw_low = 1'b0;
        viol    = 0;
        tx      = 1'b0;
        tick(4);
        tx = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (cts === 1'b0) saw_low = 1'b1;
            if (rx !== 1'b1) viol++;
        end
        checks++;
        if (!saw_low) begin
            errors++; $display("FAIL glitch_detect: got cts low=0 want 1");
        end
        checks++;
        if (total_rises != r0 || viol != 0) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d pulses %0d rx bad want 0/0",
                     total_rises - r0, viol);
        end
        checks++;
        if (cts !== 1'b1) begin
            errors++; $display("FAIL glitch_cts: got %b want 1", cts);
        end
    endtask

    task automatic test_framing();
        logic ok;
        int   r0;
        int   n;
        int   viol;
        ok = 1'b0;
        wait_cts(ok);
        r0 = total_rises;
        send_data(8'h55);
        tx = 1'b0;
        n  = 0;
        while (cts !== 1'b1 && n < 64) begin
            tick(1);
            n++;
        end
        checks++;
        if (cts !== 1'b1 || n < 8) begin
            errors++;
            $display("FAIL frame_cts: got %b after %0d clk want 1 after >=8",
                     cts, n);
        end
        tx   = 1'b1;
        viol = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (rx !== 1'b1) viol++;
        end
        checks++;
        if (total_rises != r0) begin
            errors++;
            $display("FAIL frame_no_spi: got %0d pulses want 0",
                     total_rises - r0);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL frame_no_reply: got %0d want 0", viol);
        end
        checks++;
        if (cts !== 1'b1) begin
            errors++; $display("FAIL frame_cts_end: got %b want 1", cts);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] txb [2];
        logic [7:0] slv [2];
        logic [7:0] d;
        logic       ok;
        txb[0] = 8'h00; slv[0] = 8'hC3;
        txb[1] = 8'hFF; slv[1] = 8'h5A;
        for (int k = 0; k < 2; k++) begin
            ok = 1'b0;
            wait_cts(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL b2b_cts%0d: got %b want 1", k, cts);
            end
            base       = total_rises;
            slave_data = slv[k];
            send_byte(txb[k]);
            recv_byte(d, ok);
            checks++;
            if (mosi_cap !== txb[k] || total_rises - base != 8) begin
                errors++;
                $display("FAIL b2b_mosi%0d: got %h/%0d want %h/8", k,
                         mosi_cap, total_rises - base, txb[k]);
            end
            checks++;
            if (!ok || d !== slv[k]) begin
                errors++;
                $display("FAIL b2b_reply%0d: got %h ok=%b want %h ok=1", k,
                         d, ok, slv[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic ok;
        int   n;
        ok = 1'b0;
        wait_cts(ok);
        base       = total_rises;
        slave_data = 8'h00;
        send_byte(8'hFF);
        n = 0;
        while (sck !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (sck !== 1'b1 || mosi !== 1'b1) begin
            errors++;
            $display("FAIL abort_active: got sck=%b mosi=%b want 1/1",
                     sck, mosi);
        end
        reset = 1'b0;
        tick(1);
        checks++;
        if (sck !== 1'b0 || mosi !== 1'b0 || rx !== 1'b1 || cts !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got sck=%b mosi=%b rx=%b cts=%b want 0/0/1/0",
                     sck, mosi, rx, cts);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (cts !== 1'b1) begin
            errors++; $display("FAIL abort_recover: got %b want 1", cts);
        end
    endtask

    initial begin
        test_reset();
        tick(5);
        test_basic();
        test_rts();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
